// File: rtl/fall_pkg.sv
// Shared types and constants for the falling-character scheduler:
// FSM state encoding, field widths, the slot record and the
// spawn-acceleration constants used when SPAWN_ACCEL_EN is defined.
package fall_pkg;

   localparam int CH_W  = 8;
   localparam int X_W   = 9;
   localparam int Y_W   = 10;
   localparam int SPD_W = 3;

   // Effective spawn period shrinks by one every ACCEL_STEP hits, never below ACCEL_FLOOR.
   localparam int ACCEL_STEP  = 16;
   localparam int ACCEL_FLOOR = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE,
      ST_SPAWN,
      ST_KEY_SCAN,
      ST_KEY_COMMIT
   } state_e;

   typedef struct packed {
      logic             active;
      logic [CH_W-1:0]  ch;
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic [SPD_W-1:0] speed;
   } slot_t;

endpackage

// File: rtl/fall_spawn_timer.sv
// Spawn timer: counts completed frame moves and flags when a spawn is due.
// Optional macro SPAWN_ACCEL_EN: the period starts at SPAWN_PERIOD and
// shrinks by one every ACCEL_STEP hits down to ACCEL_FLOOR.
module fall_spawn_timer
   import fall_pkg::*;
#(
   parameter int SPAWN_PERIOD = 40
) (
   input  logic clk,
   input  logic rst_n,
   input  logic adv_i,       // one frame's MOVE pass finished
   input  logic restart_i,   // spawn attempt consumed the due flag
   input  logic hit_i,       // a key hit was committed
   output logic due_o
);

   localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
   localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(SPAWN_PERIOD);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_eff;

`ifdef SPAWN_ACCEL_EN
   localparam int HC_W = $clog2(ACCEL_STEP);

   logic [CNT_W-1:0] period_q, period_d;
   logic [HC_W-1:0]  hit_cnt_q, hit_cnt_d;

   // Every ACCEL_STEP-th hit shortens the period until the floor is reached.
   always_comb begin
      period_d  = period_q;
      hit_cnt_d = hit_cnt_q;
      if (hit_i) begin
         hit_cnt_d = hit_cnt_q + HC_W'(1);
         if (hit_cnt_q == HC_W'(ACCEL_STEP - 1)) begin
            hit_cnt_d = '0;
            if (int'(period_q) > ACCEL_FLOOR) begin
               period_d = period_q - CNT_W'(1);
            end
         end
      end
   end

   // Acceleration state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q  <= PERIOD_INIT;
         hit_cnt_q <= '0;
      end else begin
         period_q  <= period_d;
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign period_eff = period_q;
`else
   logic unused_hit;
   assign unused_hit = hit_i;
   assign period_eff = PERIOD_INIT;
`endif

   // Greater-or-equal so a period that shrinks below the running count cannot stall spawning.
   assign due_o = (cnt_q >= period_eff);

   // Counter next-state: restart wins, otherwise advance once per frame.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = '0;
      end else if (adv_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Spawn counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fall_char_scheduler.sv
// Falling-character slot table for the typing game: moves slots each frame,
// retires misses at the bottom, spawns from the generator and retires the
// lowest-on-screen slot matching a keypress. Optional macro SPAWN_ACCEL_EN
// (handled inside fall_spawn_timer) speeds up spawning as hits accumulate.
module fall_char_scheduler
   import fall_pkg::*;
#(
   parameter int             SLOTS        = 8,
   parameter int             SPAWN_PERIOD = 40,
   parameter logic [X_W-1:0] X_MAX        = 9'd464
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tick_i,
   input  logic [CH_W-1:0]          gen_ch_i,
   input  logic [SPD_W-1:0]         gen_speed_i,
   input  logic [X_W-1:0]           gen_x_i,
   input  logic [Y_W-1:0]           gen_y_i,
   input  logic                     key_valid_i,
   input  logic [CH_W-1:0]          key_ch_i,
   input  logic [$clog2(SLOTS)-1:0] rd_idx_i,
   output logic                     rd_active_o,
   output logic [CH_W-1:0]          rd_ch_o,
   output logic [X_W-1:0]           rd_x_o,
   output logic [Y_W-1:0]           rd_y_o,
   output logic                     hit_o,
   output logic                     miss_o,
   output logic                     key_drop_o,
   output logic                     spawn_skip_o,
   output logic [$clog2(SLOTS):0]   active_cnt_o
);

   localparam int IDX_W = $clog2(SLOTS);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

   slot_t            slots_q [SLOTS];
   slot_t            slots_d [SLOTS];
   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             best_found_q, best_found_d;
   logic [X_W-1:0]   best_x_q, best_x_d;
   logic             tick_pend_q, tick_pend_d;
   logic             key_pend_q, key_pend_d;
   logic [CH_W-1:0]  key_ch_q, key_ch_d;
   logic [CNT_W-1:0] active_cnt_q, active_cnt_d;
   logic             hit_q, hit_d, miss_q, miss_d;
   logic             key_drop_q, key_drop_d, spawn_skip_q, spawn_skip_d;

   logic             spawn_due, cnt_adv, cnt_restart;
   logic             tick_take, key_done, set_ev, clr_ev;
   logic [SLOTS-1:0] free_vec;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   slot_t            new_slot;
   logic [X_W:0]     move_sum;

   fall_spawn_timer #(
      .SPAWN_PERIOD (SPAWN_PERIOD)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv_i     (cnt_adv),
      .restart_i (cnt_restart),
      .hit_i     (hit_q),
      .due_o     (spawn_due)
   );

   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_free
      assign free_vec[gi] = ~slots_q[gi].active;
   end

   // Lowest-index free slot; scanning downwards leaves the lowest one last.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (free_vec[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // New slot image from the generator; a zero speed would never fall, so it becomes 1.
   always_comb begin
      new_slot        = '0;
      new_slot.active = 1'b1;
      new_slot.ch     = gen_ch_i;
      new_slot.x      = gen_x_i;
      new_slot.y      = gen_y_i;
      new_slot.speed  = (gen_speed_i == '0) ? SPD_W'(1) : gen_speed_i;
   end

   // Position after this frame, one bit wider so a bottom crossing cannot wrap.
   assign move_sum = {1'b0, slots_q[idx_q].x} + {{(X_W + 1 - SPD_W){1'b0}}, slots_q[idx_q].speed};

   // Scheduler FSM next-state, slot writes and event pulses.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      best_idx_d   = best_idx_q;
      best_found_d = best_found_q;
      best_x_d     = best_x_q;
      slots_d      = slots_q;
      hit_d        = 1'b0;
      miss_d       = 1'b0;
      spawn_skip_d = 1'b0;
      cnt_adv      = 1'b0;
      cnt_restart  = 1'b0;
      tick_take    = 1'b0;
      key_done     = 1'b0;
      set_ev       = 1'b0;
      clr_ev       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick_pend_q) begin
               tick_take = 1'b1;
               idx_d     = '0;
               state_d   = ST_MOVE;
            end else if (key_pend_q) begin
               idx_d        = '0;
               best_found_d = 1'b0;
               best_idx_d   = '0;
               best_x_d     = '0;
               state_d      = ST_KEY_SCAN;
            end
         end
         ST_MOVE: begin
            if (slots_q[idx_q].active) begin
               if (move_sum >= {1'b0, X_MAX}) begin
                  slots_d[idx_q] = '0;
                  miss_d         = 1'b1;
                  clr_ev         = 1'b1;
               end else begin
                  slots_d[idx_q].x = move_sum[X_W-1:0];
               end
            end
            if (idx_q == LAST_IDX) begin
               cnt_adv = 1'b1;
               state_d = ST_SPAWN;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_SPAWN: begin
            if (spawn_due) begin
               cnt_restart = 1'b1;
               if (free_found) begin
                  slots_d[free_idx] = new_slot;
                  set_ev            = 1'b1;
               end else begin
                  spawn_skip_d = 1'b1;
               end
            end
            state_d = ST_IDLE;
         end
         ST_KEY_SCAN: begin
            // Strict greater-than keeps the earlier (lower) index on equal x.
            if (slots_q[idx_q].active && (slots_q[idx_q].ch == key_ch_q) &&
                (!best_found_q || (slots_q[idx_q].x > best_x_q))) begin
               best_found_d = 1'b1;
               best_idx_d   = idx_q;
               best_x_d     = slots_q[idx_q].x;
            end
            if (idx_q == LAST_IDX) begin
               state_d = ST_KEY_COMMIT;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_KEY_COMMIT: begin
            if (best_found_q) begin
               slots_d[best_idx_q] = '0;
               hit_d               = 1'b1;
               clr_ev              = 1'b1;
            end
            key_done = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pending latches and occupancy count; a key arriving while one waits is dropped.
   always_comb begin
      tick_pend_d  = (tick_pend_q && !tick_take) || tick_i;
      key_pend_d   = key_pend_q && !key_done;
      key_ch_d     = key_ch_q;
      key_drop_d   = key_valid_i && key_pend_q;
      if (key_valid_i && !key_pend_q) begin
         key_pend_d = 1'b1;
         key_ch_d   = key_ch_i;
      end
      active_cnt_d = active_cnt_q;
      if (set_ev) begin
         active_cnt_d = active_cnt_q + CNT_W'(1);
      end else if (clr_ev) begin
         active_cnt_d = active_cnt_q - CNT_W'(1);
      end
   end

   // Control, latch and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         best_idx_q   <= '0;
         best_found_q <= 1'b0;
         best_x_q     <= '0;
         tick_pend_q  <= 1'b0;
         key_pend_q   <= 1'b0;
         key_ch_q     <= '0;
         active_cnt_q <= '0;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         key_drop_q   <= 1'b0;
         spawn_skip_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         best_idx_q   <= best_idx_d;
         best_found_q <= best_found_d;
         best_x_q     <= best_x_d;
         tick_pend_q  <= tick_pend_d;
         key_pend_q   <= key_pend_d;
         key_ch_q     <= key_ch_d;
         active_cnt_q <= active_cnt_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         key_drop_q   <= key_drop_d;
         spawn_skip_q <= spawn_skip_d;
      end
   end

   // Slot table register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SLOTS; i++) begin
            slots_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            slots_q[i] <= slots_d[i];
         end
      end
   end

   assign rd_active_o  = slots_q[rd_idx_i].active;
   assign rd_ch_o      = slots_q[rd_idx_i].ch;
   assign rd_x_o       = slots_q[rd_idx_i].x;
   assign rd_y_o       = slots_q[rd_idx_i].y;
   assign hit_o        = hit_q;
   assign miss_o       = miss_q;
   assign key_drop_o   = key_drop_q;
   assign spawn_skip_o = spawn_skip_q;
   assign active_cnt_o = active_cnt_q;

endmodule
